// File: rtl/hamming74_if.sv
// Handshake and serial-output bundle between a nibble source and hamming74_tx.
interface hamming74_if;
   logic [3:0] data_in;
   logic       in_valid;
   logic       in_ready;
   logic       tx_bit;
   logic       tx_frame;
   logic       tx_last;
   logic [7:0] frame_count;

   modport master (
      output data_in, in_valid,
      input  in_ready, tx_bit, tx_frame, tx_last, frame_count
   );

   modport slave (
      input  data_in, in_valid,
      output in_ready, tx_bit, tx_frame, tx_last, frame_count
   );
endinterface

// File: rtl/hamming74_tx.sv
// Serial Hamming(7,4) encoder: captures a nibble on valid/ready, then shifts
// p1,p2,d1,p4,d2,d3,d4 out one bit per clock with frame/last strobes.
module hamming74_tx #(
   parameter int GAP = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   hamming74_if.slave  bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

   localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

   // Bit 0 of the result is transmitted first (codeword position 1).
   function automatic logic [6:0] encode(input logic [3:0] d);
      logic p1, p2, p4;
      p1 = d[0] ^ d[1] ^ d[3];
      p2 = d[0] ^ d[2] ^ d[3];
      p4 = d[1] ^ d[2] ^ d[3];
      return {d[3], d[2], d[1], p4, d[0], p2, p1};
   endfunction

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] gap_q, gap_d;
   logic [3:0] data_q, data_d;
   logic       tx_bit_q, tx_bit_d;
   logic       tx_frame_q, tx_frame_d;
   logic       tx_last_q, tx_last_d;
   logic [7:0] count_q, count_d;
   logic [6:0] cw_in;
   logic [6:0] cw_cur;

   assign cw_in  = encode(bus.data_in);
   assign cw_cur = encode(data_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         gap_q      <= '0;
         data_q     <= '0;
         tx_bit_q   <= 1'b0;
         tx_frame_q <= 1'b0;
         tx_last_q  <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         data_q     <= data_d;
         tx_bit_q   <= tx_bit_d;
         tx_frame_q <= tx_frame_d;
         tx_last_q  <= tx_last_d;
         count_q    <= count_d;
      end
   end

   // Outputs are registered: the value computed here appears in the next cycle,
   // so the first codeword bit is loaded directly from data_in on the transfer edge.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      gap_d      = gap_q;
      data_d     = data_q;
      tx_bit_d   = 1'b0;
      tx_frame_d = 1'b0;
      tx_last_d  = 1'b0;
      count_d    = count_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_d    = ST_SEND;
               idx_d      = '0;
               data_d     = bus.data_in;
               tx_bit_d   = cw_in[0];
               tx_frame_d = 1'b1;
            end
         end
         ST_SEND: begin
            if (idx_q == 3'd6) begin
               count_d = count_q + 8'd1;
               gap_d   = '0;
               state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
            end else begin
               idx_d      = idx_q + 3'd1;
               tx_bit_d   = cw_cur[idx_q + 3'd1];
               tx_frame_d = 1'b1;
               tx_last_d  = (idx_q == 3'd5);
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) state_d = ST_IDLE;
            else                   gap_d   = gap_q + 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.in_ready    = (state_q == ST_IDLE);
   assign bus.tx_bit      = tx_bit_q;
   assign bus.tx_frame    = tx_frame_q;
   assign bus.tx_last     = tx_last_q;
   assign bus.frame_count = count_q;

endmodule
